// File: rtl/game_flow_ctrl_pkg.sv
// Shared types for the game sequencer: the top-level state encoding and the
// width of the frame counter that times the hit, game-over and win phases.
package game_pkg;

  typedef enum logic [2:0] {
    ST_START = 3'd0,
    ST_PLAY  = 3'd1,
    ST_HIT   = 3'd2,
    ST_OVER  = 3'd3,
    ST_WIN   = 3'd4
  } game_state_t;

  localparam int FRAME_CNT_W = 8;

endpackage

// File: rtl/game_flow_ctrl_frame_timer.sv
// Saturating video-frame counter with synchronous clear and a limit compare.
// done fires on the frame pulse that arrives while the count equals the limit.
module frame_timer
  import game_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   enable,
  input  logic                   tick,
  input  logic [FRAME_CNT_W-1:0] limit,
  output logic [FRAME_CNT_W-1:0] cnt_next,
  output logic                   done
);

  localparam logic [FRAME_CNT_W-1:0] CNT_MAX  = {FRAME_CNT_W{1'b1}};
  localparam logic [FRAME_CNT_W-1:0] CNT_ZERO = {FRAME_CNT_W{1'b0}};
  localparam logic [FRAME_CNT_W-1:0] CNT_ONE  = FRAME_CNT_W'(1);

  logic [FRAME_CNT_W-1:0] cnt_r;

  // clear wins over counting so a frame pulse on state entry is not counted
  always_comb begin
    done = enable & tick & (cnt_r == limit);
    if (clear) begin
      cnt_next = CNT_ZERO;
    end else if (enable && tick && (cnt_r != CNT_MAX)) begin
      cnt_next = cnt_r + CNT_ONE;
    end else begin
      cnt_next = cnt_r;
    end
  end

  // counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= CNT_ZERO;
    end else begin
      cnt_r <= cnt_next;
    end
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// Game sequencer: START/PLAY/HIT/OVER/WIN flow, lives bookkeeping and the
// registered overlay/motion enables that feed the VGA objects mux.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int LIVES       = 3,
  parameter int HIT_FRAMES  = 60,
  parameter int OVER_FRAMES = 180,
  parameter int WIN_FRAMES  = 180
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       startKey,
  input  logic       hitPulse,
  input  logic       winPulse,
  output logic       showStart,
  output logic       showOver,
  output logic       showWin,
  output logic       gameRun,
  output logic       hitFlash,
  output logic [2:0] livesLeft,
  output logic       newGame
);

  localparam logic [FRAME_CNT_W-1:0] HIT_LIM  = FRAME_CNT_W'(HIT_FRAMES - 1);
  localparam logic [FRAME_CNT_W-1:0] OVER_LIM = FRAME_CNT_W'(OVER_FRAMES - 1);
  localparam logic [FRAME_CNT_W-1:0] WIN_LIM  = FRAME_CNT_W'(WIN_FRAMES - 1);
  localparam logic [2:0]             LIVES_INIT = 3'(LIVES);

  game_state_t            state_r, state_next_s;
  logic                   key_d_r, key_rise_s;
  logic                   clear_s, enable_s, done_s;
  logic [FRAME_CNT_W-1:0] limit_s, cnt_next_s;
  logic [2:0]             lives_next_s;
  logic                   new_game_s, flash_next_s;

  assign key_rise_s = startKey & ~key_d_r;
  assign clear_s    = (state_next_s != state_r);

  frame_timer u_frame_timer (
    .clk      (clk),
    .rst_n    (resetN),
    .clear    (clear_s),
    .enable   (enable_s),
    .tick     (startOfFrame),
    .limit    (limit_s),
    .cnt_next (cnt_next_s),
    .done     (done_s)
  );

  // state, key edge register and registered outputs (decoded from next state)
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r   <= ST_START;
      key_d_r   <= 1'b0;
      showStart <= 1'b1;
      showOver  <= 1'b0;
      showWin   <= 1'b0;
      gameRun   <= 1'b0;
      hitFlash  <= 1'b0;
      livesLeft <= LIVES_INIT;
      newGame   <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      key_d_r   <= startKey;
      showStart <= (state_next_s == ST_START);
      showOver  <= (state_next_s == ST_OVER);
      showWin   <= (state_next_s == ST_WIN);
      gameRun   <= (state_next_s == ST_PLAY);
      hitFlash  <= flash_next_s;
      livesLeft <= lives_next_s;
      newGame   <= new_game_s;
    end
  end

  // next-state logic plus the per-state timer limit
  always_comb begin
    state_next_s = state_r;
    enable_s     = 1'b0;
    limit_s      = {FRAME_CNT_W{1'b1}};
    case (state_r)
      ST_START: begin
        if (key_rise_s) state_next_s = ST_PLAY;
        else            state_next_s = ST_START;
      end
      ST_PLAY: begin
        if (winPulse)                             state_next_s = ST_WIN;
        else if (hitPulse && (livesLeft == 3'd1)) state_next_s = ST_OVER;
        else if (hitPulse)                        state_next_s = ST_HIT;
        else                                      state_next_s = ST_PLAY;
      end
      ST_HIT: begin
        enable_s = 1'b1;
        limit_s  = HIT_LIM;
        if (done_s) state_next_s = ST_PLAY;
        else        state_next_s = ST_HIT;
      end
      ST_OVER: begin
        enable_s = 1'b1;
        limit_s  = OVER_LIM;
        if (done_s || key_rise_s) state_next_s = ST_START;
        else                      state_next_s = ST_OVER;
      end
      ST_WIN: begin
        enable_s = 1'b1;
        limit_s  = WIN_LIM;
        if (done_s || key_rise_s) state_next_s = ST_START;
        else                      state_next_s = ST_WIN;
      end
      default: state_next_s = ST_START;
    endcase
  end

  // lives bookkeeping, new-game pulse and blink decode
  always_comb begin
    lives_next_s = livesLeft;
    new_game_s   = 1'b0;
    flash_next_s = (state_next_s == ST_HIT) & cnt_next_s[0];
    case (state_r)
      ST_START: begin
        if (key_rise_s) begin
          lives_next_s = LIVES_INIT;
          new_game_s   = 1'b1;
        end else begin
          lives_next_s = livesLeft;
        end
      end
      ST_PLAY: begin
        if (!winPulse && hitPulse) lives_next_s = livesLeft - 3'd1;
        else                       lives_next_s = livesLeft;
      end
      default: lives_next_s = livesLeft;
    endcase
  end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: hand-computed expectations checked with
// immediate assertions one clock step at a time.
module tb_game_flow_ctrl;

  logic       clk = 1'b0;
  logic       resetN;
  logic       startOfFrame, startKey, hitPulse, winPulse;
  logic       showStart, showOver, showWin, gameRun, hitFlash, newGame;
  logic [2:0] livesLeft;

  int n_cmp = 0;
  int n_err = 0;

  game_flow_ctrl #(.LIVES(3), .HIT_FRAMES(60), .OVER_FRAMES(180), .WIN_FRAMES(180)) dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .startKey     (startKey),
    .hitPulse     (hitPulse),
    .winPulse     (winPulse),
    .showStart    (showStart),
    .showOver     (showOver),
    .showWin      (showWin),
    .gameRun      (gameRun),
    .hitFlash     (hitFlash),
    .livesLeft    (livesLeft),
    .newGame      (newGame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // start, over, win, run, flash, lives, newGame
  task automatic chk_all(input string tag, input logic s, input logic o, input logic w,
                         input logic r, input logic f, input logic [2:0] l, input logic n);
    chk({tag, ".showStart"}, 8'(showStart), 8'(s));
    chk({tag, ".showOver"},  8'(showOver),  8'(o));
    chk({tag, ".showWin"},   8'(showWin),   8'(w));
    chk({tag, ".gameRun"},   8'(gameRun),   8'(r));
    chk({tag, ".hitFlash"},  8'(hitFlash),  8'(f));
    chk({tag, ".livesLeft"}, 8'(livesLeft), 8'(l));
    chk({tag, ".newGame"},   8'(newGame),   8'(n));
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // one frame pulse followed by one idle clock
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      startOfFrame = 1'b1;
      step(1);
      startOfFrame = 1'b0;
      step(1);
    end
  endtask

  task automatic key_press();
    startKey = 1'b1;
    step(1);
  endtask

  task automatic key_release();
    startKey = 1'b0;
    step(1);
  endtask

  task automatic hit();
    hitPulse = 1'b1;
    step(1);
    hitPulse = 1'b0;
  endtask

  initial begin
    resetN = 1'b0; startOfFrame = 1'b0; startKey = 1'b0; hitPulse = 1'b0; winPulse = 1'b0;
    step(3);
    chk_all("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0);
    resetN = 1'b1;
    step(2);
    hit();
    winPulse = 1'b1; step(1); winPulse = 1'b0;
    chk_all("start_ignores_pulses", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0);

    key_press();
    chk_all("start_to_play", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b1);
    step(1);
    chk("newgame_one_clk", 8'(newGame), 8'd0);
    key_release();
    chk("key_held_no_retrigger", 8'(gameRun), 8'd1);

    hit();
    chk_all("hit1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0);
    frames(1);
    chk("flash_frame1", 8'(hitFlash), 8'd1);
    frames(1);
    chk("flash_frame2", 8'(hitFlash), 8'd0);
    hit();
    winPulse = 1'b1; step(1); winPulse = 1'b0;
    chk_all("hit_invulnerable", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0);
    frames(57);
    chk("hit_frame59_still_frozen", 8'(gameRun), 8'd0);
    chk("flash_frame59", 8'(hitFlash), 8'd1);
    frames(1);
    chk_all("hit1_back_to_play", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0);

    hit();
    chk("hit2_lives", 8'(livesLeft), 8'd1);
    frames(60);
    chk("hit2_back_to_play", 8'(gameRun), 8'd1);
    hit();
    chk_all("hit3_over", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    frames(179);
    chk("over_frame179", 8'(showOver), 8'd1);
    frames(1);
    chk_all("over_to_start", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);

    key_press();
    chk_all("game2_start", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b1);
    key_release();
    hitPulse = 1'b1; winPulse = 1'b1;
    step(1);
    hitPulse = 1'b0; winPulse = 1'b0;
    chk_all("win_priority", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0);
    frames(10);
    chk("win_frame10", 8'(showWin), 8'd1);
    key_press();
    chk_all("win_key_to_start", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0);
    key_release();
    key_press();
    chk_all("game3_start", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b1);
    key_release();

    hit();
    frames(29);
    chk_all("hit_frame29", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0);
    frames(1);
    resetN = 1'b0;
    #1;
    chk_all("async_reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0);
    step(1);
    resetN = 1'b1;
    step(1);
    chk("after_reset_start", 8'(showStart), 8'd1);
    key_press();
    key_release();
    hit();
    frames(1);
    chk("fresh_counter_flash", 8'(hitFlash), 8'd1);
    frames(58);
    chk("fresh_counter_frame59", 8'(gameRun), 8'd0);
    frames(1);
    chk("fresh_counter_frame60", 8'(gameRun), 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
